hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- ID-stage hazard detection for the 5-stage pipelined MIPS; sits directly upstream of forwardunit.
- Decides how many bubbles the instruction in IF/ID needs before it may enter ID/EX, so that forwardunit (forwarding on) or the register file (forwarding off) can supply correct operands.
- Drives PC/IF-ID write enables and the ID/EX bubble select through a small stall FSM.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 16: width of the stall_count performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- forward_btn  in  1  1 = forwarding enabled (same mode bit forwardunit uses); 0 = forwarding disabled.
- branch_flush  in  1  IF/ID is being flushed this cycle (taken branch/jump).
- IF_ID_Regrs  in  5  rs of the instruction in ID.
- IF_ID_Regrt  in  5  rt of the instruction in ID.
- IF_ID_use_rs  in  1  ID instruction reads rs.
- IF_ID_use_rt  in  1  ID instruction reads rt.
- ID_EX_Regrd  in  5  destination register (after RegDst mux) of the instruction in EX.
- ID_EX_Regwrite  in  1  EX instruction writes the register file.
- ID_EX_Memread  in  1  EX instruction is a load.
- EX_MEM_Regrd  in  5  destination register of the instruction in MEM.
- EX_MEM_Regwrite  in  1  MEM instruction writes the register file.
- PC_write  out  1  1 = PC may update.
- IF_ID_write  out  1  1 = IF/ID may load.
- ID_EX_bubble  out  1  1 = ID/EX loads all-zero control (nop).
- forward_stallstrt  out  1  high only in the first cycle of each stall episode.
- stall_active  out  1  FSM is in STALL state.
- stall_count  out  CNT_W  total bubble cycles inserted since reset; saturates at all-ones.

Behaviour:
- Match rules:
  - matchX(r) = X_Regwrite & (X_Regrd == r) & (r != 0), for r in {rs, rt}.
  - Each operand is gated by its use bit.
  - Register 0 never causes a hazard.
- Bubbles needed, need (0..2):
  - forward_btn=1: need = 1 if ID_EX_Memread & ID_EX match on a used operand; else 0.
  - forward_btn=0: need = 2 if any ID_EX match; else 1 if any EX_MEM match; else 0. The register file is write-first, so MEM/WB writers never stall.
  - Multiple matches: need = the maximum.
- FSM states: IDLE and STALL, plus a 2-bit remaining counter rem.
- IDLE, need=0: PC_write=1, IF_ID_write=1, ID_EX_bubble=0.
- IDLE, need>0, branch_flush=0, same cycle (combinational):
  - PC_write=0, IF_ID_write=0, ID_EX_bubble=1, forward_stallstrt=1, stall_count += 1.
  - need=1: stay IDLE. The next cycle re-evaluates with the writer one stage further down.
  - need=2: go to STALL with rem=1.
- STALL:
  - PC_write=0, IF_ID_write=0, ID_EX_bubble=1, forward_stallstrt=0, stall_count += 1.
  - Match inputs and forward_btn are ignored.
  - rem==1: go to IDLE, rem=0.
- forward_btn is sampled only at stall start; a toggle mid-stall does not change the episode length.
- branch_flush=1 in either state:
  - No stall this cycle: PC_write=1, IF_ID_write=1, ID_EX_bubble=0, forward_stallstrt=0, no count.
  - Next state IDLE, rem=0. The flushed instruction must not be held.
- stall_count: increments once per bubble cycle; holds at 2^CNT_W-1.
- Reset:
  - rst_n low asynchronously forces state IDLE, rem=0, stall_count=0.
  - While rst_n is low, outputs read PC_write=1, IF_ID_write=1, ID_EX_bubble=0, forward_stallstrt=0, stall_active=0, independent of the match inputs.
  - Reset during STALL abandons the episode.
- Latency: hazard response is combinational in the detection cycle; state, rem and stall_count update on the rising edge.

Test Plan:
- forward_btn=1, ID_EX_Memread=1, ID_EX_Regwrite=1, ID_EX_Regrd=8, IF_ID_Regrs=8, use_rs=1; next cycle ID_EX inputs cleared (bubble) -> exactly 1 cycle with PC_write=0, ID_EX_bubble=1, forward_stallstrt=1; stall_count 0->1.
- forward_btn=1, ID_EX_Memread=0 (ALU op), same register match -> no stall, PC_write=1, stall_count unchanged.
- forward_btn=0, ID_EX_Regwrite=1, ID_EX_Regrd=5, IF_ID_Regrt=5, use_rt=1 -> 2 consecutive bubble cycles; stall_active=1 only in the second; forward_stallstrt only in the first; stall_count +2.
- forward_btn=0, only EX_MEM_Regrd=5 matches with EX_MEM_Regwrite=1 -> 1 bubble. Same match on register 0 -> no bubble.
- Enter 2-cycle stall, assert branch_flush in the STALL cycle -> that cycle PC_write=1, ID_EX_bubble=0; next state IDLE; count +1 only. Repeat with rst_n pulsed low mid-stall -> immediate IDLE, stall_count=0.
- Preload stall_count near all-ones (CNT_W=4 build), force 20 bubbles -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage load-use / no-forwarding hazard stall unit
//
// Works out how many bubbles the instruction in IF/ID needs before it may
// enter ID/EX, then holds PC and IF/ID and injects nops into ID/EX for that
// many cycles. With forwarding on, only a load in EX feeding the ID
// instruction needs one bubble. With forwarding off, a writer in EX needs two
// bubbles and a writer in MEM needs one. The register file is write-first, so
// a writer in WB never stalls.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   forward_btn         1 = forwarding enabled
//   branch_flush        IF/ID is being flushed this cycle
//   IF_ID_*             source registers and use bits of the ID instruction
//   ID_EX_*             destination / write / load flags of the EX instruction
//   EX_MEM_*            destination / write flag of the MEM instruction
//   PC_write            1 = PC may update
//   IF_ID_write         1 = IF/ID may load
//   ID_EX_bubble        1 = ID/EX loads nop control
//   forward_stallstrt   high in the first cycle of each stall episode
//   stall_active        FSM is in the STALL state
//   stall_count         saturating count of bubble cycles since reset

module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             forward_btn,
  input  logic             branch_flush,
  input  logic [4:0]       IF_ID_Regrs,
  input  logic [4:0]       IF_ID_Regrt,
  input  logic             IF_ID_use_rs,
  input  logic             IF_ID_use_rt,
  input  logic [4:0]       ID_EX_Regrd,
  input  logic             ID_EX_Regwrite,
  input  logic             ID_EX_Memread,
  input  logic [4:0]       EX_MEM_Regrd,
  input  logic             EX_MEM_Regwrite,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             forward_stallstrt,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       ex_rs, ex_rt, mem_rs, mem_rt;
  logic       ex_hit, mem_hit;
  logic [1:0] need;
  logic       stall_start;
  logic       stall_hold;
  logic       bubble;

  // Operand matches; register 0 is hard-wired and never a hazard source.
  always_comb begin
    ex_rs   = ID_EX_Regwrite  & IF_ID_use_rs & (ID_EX_Regrd  == IF_ID_Regrs) & (IF_ID_Regrs != 5'd0);
    ex_rt   = ID_EX_Regwrite  & IF_ID_use_rt & (ID_EX_Regrd  == IF_ID_Regrt) & (IF_ID_Regrt != 5'd0);
    mem_rs  = EX_MEM_Regwrite & IF_ID_use_rs & (EX_MEM_Regrd == IF_ID_Regrs) & (IF_ID_Regrs != 5'd0);
    mem_rt  = EX_MEM_Regwrite & IF_ID_use_rt & (EX_MEM_Regrd == IF_ID_Regrt) & (IF_ID_Regrt != 5'd0);
    ex_hit  = ex_rs | ex_rt;
    mem_hit = mem_rs | mem_rt;
  end

  // Bubble requirement, taking the worst case over both operands.
  always_comb begin
    need = 2'd0;
    if (forward_btn) begin
      if (ID_EX_Memread && ex_hit) need = 2'd1;
    end else begin
      if (ex_hit)       need = 2'd2;
      else if (mem_hit) need = 2'd1;
    end
  end

  // rst_n gates the stall terms so outputs read "run" while reset is held,
  // whatever the match inputs say.
  always_comb begin
    stall_start = rst_n & (state_q == IDLE)  & (need != 2'd0) & ~branch_flush;
    stall_hold  = rst_n & (state_q == STALL) & ~branch_flush;
    bubble      = stall_start | stall_hold;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A one-bubble hazard stays in IDLE and is re-evaluated
  // next cycle with the writer one stage further down the pipe.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (stall_start && need == 2'd2) begin
          state_d = STALL;
          rem_d   = need - 2'd1;
        end
      end
      STALL: begin
        if (branch_flush || rem_q <= 2'd1) begin
          state_d = IDLE;
          rem_d   = 2'd0;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 2'd0;
      end
    endcase
    if (bubble && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  // Output logic
  always_comb begin
    PC_write          = ~bubble;
    IF_ID_write       = ~bubble;
    ID_EX_bubble      = bubble;
    forward_stallstrt = stall_start;
    stall_active      = rst_n & (state_q == STALL);
    stall_count       = cnt_q;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard testbench for hazard_stall_unit

module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       forward_btn = 1'b0, branch_flush = 1'b0;
  logic [4:0] IF_ID_Regrs = '0, IF_ID_Regrt = '0, ID_EX_Regrd = '0, EX_MEM_Regrd = '0;
  logic       IF_ID_use_rs = 1'b0, IF_ID_use_rt = 1'b0;
  logic       ID_EX_Regwrite = 1'b0, ID_EX_Memread = 1'b0, EX_MEM_Regwrite = 1'b0;

  logic        pcw, ifw, bub, strt, act;
  logic [15:0] cnt;
  logic        pcw4, ifw4, bub4, strt4, act4;
  logic [3:0]  cnt4;

  hazard_stall_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .forward_btn(forward_btn), .branch_flush(branch_flush),
    .IF_ID_Regrs(IF_ID_Regrs), .IF_ID_Regrt(IF_ID_Regrt),
    .IF_ID_use_rs(IF_ID_use_rs), .IF_ID_use_rt(IF_ID_use_rt),
    .ID_EX_Regrd(ID_EX_Regrd), .ID_EX_Regwrite(ID_EX_Regwrite), .ID_EX_Memread(ID_EX_Memread),
    .EX_MEM_Regrd(EX_MEM_Regrd), .EX_MEM_Regwrite(EX_MEM_Regwrite),
    .PC_write(pcw), .IF_ID_write(ifw), .ID_EX_bubble(bub),
    .forward_stallstrt(strt), .stall_active(act), .stall_count(cnt)
  );

  hazard_stall_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .forward_btn(forward_btn), .branch_flush(branch_flush),
    .IF_ID_Regrs(IF_ID_Regrs), .IF_ID_Regrt(IF_ID_Regrt),
    .IF_ID_use_rs(IF_ID_use_rs), .IF_ID_use_rt(IF_ID_use_rt),
    .ID_EX_Regrd(ID_EX_Regrd), .ID_EX_Regwrite(ID_EX_Regwrite), .ID_EX_Memread(ID_EX_Memread),
    .EX_MEM_Regrd(EX_MEM_Regrd), .EX_MEM_Regwrite(EX_MEM_Regwrite),
    .PC_write(pcw4), .IF_ID_write(ifw4), .ID_EX_bubble(bub4),
    .forward_stallstrt(strt4), .stall_active(act4), .stall_count(cnt4)
  );

  typedef struct {
    logic       rst_n, fwd, flush;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt;
    logic [4:0] exrd;
    logic       exw, exmr;
    logic [4:0] memrd;
    logic       memw;
    logic       e_pcw, e_bub, e_strt, e_act;
  } vec_t;

  typedef struct {
    string       name;
    logic        pcw, bub, strt, act;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic r, logic f, logic fl, logic [4:0] rs, logic [4:0] rt,
                              logic urs, logic urt, logic [4:0] exrd, logic exw, logic exmr,
                              logic [4:0] memrd, logic memw,
                              logic pc, logic b, logic s, logic a);
    vec_t v;
    v.rst_n = r; v.fwd = f; v.flush = fl; v.rs = rs; v.rt = rt;
    v.use_rs = urs; v.use_rt = urt; v.exrd = exrd; v.exw = exw; v.exmr = exmr;
    v.memrd = memrd; v.memw = memw;
    v.e_pcw = pc; v.e_bub = b; v.e_strt = s; v.e_act = a;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act_v, logic [15:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  // Monitor: every cycle the DUT presents a response, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".PC_write"},          {15'd0, pcw},  {15'd0, e.pcw});
      chk({e.name, ".IF_ID_write"},       {15'd0, ifw},  {15'd0, e.pcw});
      chk({e.name, ".ID_EX_bubble"},      {15'd0, bub},  {15'd0, e.bub});
      chk({e.name, ".forward_stallstrt"}, {15'd0, strt}, {15'd0, e.strt});
      chk({e.name, ".stall_active"},      {15'd0, act},  {15'd0, e.act});
      chk({e.name, ".stall_count"},       cnt,           e.cnt);
      chk({e.name, ".stall_count4"},      {12'd0, cnt4}, {12'd0, e.cnt4});
    end
  end

  initial begin
    logic [15:0] ecnt;
    logic [3:0]  ecnt4;
    int          wait_cycles;
    ecnt = '0;
    ecnt4 = '0;

    //            rst f fl rs rt urs urt exrd exw exmr memrd memw  pcw bub strt act
    // reset held with a live hazard on the inputs
    vecs.push_back(mk(0, 0, 0, 0, 5, 0, 1, 5, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    // forwarding on, load-use: exactly one bubble
    vecs.push_back(mk(1, 1, 0, 8, 0, 1, 0, 8, 1, 1, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 8, 0, 1, 0, 0, 0, 0, 8, 0,  1, 0, 0, 0));
    // forwarding on, ALU producer: no stall
    vecs.push_back(mk(1, 1, 0, 8, 0, 1, 0, 8, 1, 0, 0, 0,  1, 0, 0, 0));
    // forwarding off, EX writer on rt: two bubbles, second in STALL
    vecs.push_back(mk(1, 0, 0, 0, 5, 0, 1, 5, 1, 0, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 5, 0, 1, 5, 1, 0, 0, 0,  0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    // forwarding off, MEM writer only: one bubble
    vecs.push_back(mk(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 5, 1,  0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    // register 0 never hazards; unused operand never hazards
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1,  1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 7, 0, 0, 0, 7, 1, 1, 0, 0,  1, 0, 0, 0));
    // EX and MEM both match: worst case (two) wins
    vecs.push_back(mk(1, 0, 0, 3, 4, 1, 1, 3, 1, 0, 4, 1,  0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 3, 4, 1, 1, 0, 0, 0, 3, 1,  0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    // flush in the STALL cycle releases the pipe
    vecs.push_back(mk(1, 0, 0, 5, 0, 1, 0, 5, 1, 0, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 5, 0, 1, 0, 0, 0, 0, 5, 1,  1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    // flush in IDLE masks a fresh hazard
    vecs.push_back(mk(1, 0, 1, 5, 0, 1, 0, 5, 1, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    // forwarding toggled on mid-stall does not shorten the episode
    vecs.push_back(mk(1, 0, 0, 9, 0, 1, 0, 9, 1, 0, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    // reset mid-stall abandons the episode and clears the counter
    vecs.push_back(mk(1, 0, 0, 5, 0, 1, 0, 5, 1, 0, 0, 0,  0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 5, 1,  1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    // 20 consecutive single bubbles: the 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 5, 1,  0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      rst_n           = vecs[i].rst_n;
      forward_btn     = vecs[i].fwd;
      branch_flush    = vecs[i].flush;
      IF_ID_Regrs     = vecs[i].rs;
      IF_ID_Regrt     = vecs[i].rt;
      IF_ID_use_rs    = vecs[i].use_rs;
      IF_ID_use_rt    = vecs[i].use_rt;
      ID_EX_Regrd     = vecs[i].exrd;
      ID_EX_Regwrite  = vecs[i].exw;
      ID_EX_Memread   = vecs[i].exmr;
      EX_MEM_Regrd    = vecs[i].memrd;
      EX_MEM_Regwrite = vecs[i].memw;
      if (!vecs[i].rst_n) begin
        ecnt  = '0;
        ecnt4 = '0;
      end
      e.name = $sformatf("v%0d", i);
      e.pcw  = vecs[i].e_pcw;
      e.bub  = vecs[i].e_bub;
      e.strt = vecs[i].e_strt;
      e.act  = vecs[i].e_act;
      e.cnt  = ecnt;
      e.cnt4 = ecnt4;
      exp_q.push_back(e);
      if (vecs[i].rst_n && vecs[i].e_bub) begin
        if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
        if (ecnt4 != 4'hF)    ecnt4 = ecnt4 + 4'd1;
      end
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
